// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 32-bit integer ALU with a combinational result/zero path and a
//            one-cycle registered copy of both outputs.
// Revision : 1.0  initial release
// ============================================================================
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] result_q,
    output logic        zero_q
);

    // Operation encoding
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;

    // Only the low five bits of b select the shift distance; upper bits are
    // deliberately ignored so an amount of 32 wraps to 0.
    logic [4:0] w_shamt;
    logic       w_lt_signed;
    logic       w_lt_unsigned;

    assign w_shamt       = b[4:0];
    assign w_lt_signed   = $signed(a) < $signed(b);
    assign w_lt_unsigned = a < b;

    // Combinational operation select; unused encodings are left as X so
    // synthesis is free to pick whatever logic is cheapest.
    always_comb begin
        result = 'x;
        case (alu_control)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << w_shamt;
            OP_SRL:  result = a >> w_shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            OP_SLT:  result = {31'b0, w_lt_signed};
            OP_SLTU: result = {31'b0, w_lt_unsigned};
            OP_LUI:  result = b;
            default: result = 'x;
        endcase
    end

    // Zero flag is derived from the final result for every operation.
    assign zero = ~|result;

    // Registered copy of the outputs; reset forces a zero result with the
    // zero flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= 32'h0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Scoreboard testbench for alu using directed vectors with
//            hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    typedef struct {
        string       name;
        logic [31:0] exp_res;
        logic        exp_zero;
        bit          res_is_x;
        logic [31:0] exp_q;
        logic        exp_zq;
        bit          chk_q;
    } exp_t;

    exp_t sb_q[$];
    int   tests;
    int   fails;
    bit   done;
    bit   four_state;

    alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .result_q    (result_q),
        .zero_q      (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector on the falling edge and queue what the next rising
    // edge should show (combinational result still held, registered copy).
    task automatic vec(input string name, input logic [3:0] op,
                       input logic [31:0] va, input logic [31:0] vb,
                       input bit rn, input logic [31:0] exp, input bit isx);
        exp_t e;
        @(negedge clk);
        rst_n       = rn;
        a           = va;
        b           = vb;
        alu_control = op;
        e.name     = name;
        e.exp_res  = exp;
        e.exp_zero = (exp == 32'h0);
        e.res_is_x = isx;
        e.exp_q    = rn ? exp : 32'h0;
        e.exp_zq   = rn ? (exp == 32'h0) : 1'b1;
        e.chk_q    = !(isx && rn);
        sb_q.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge, checked 1 time unit
    // after the edge while the inputs are still stable.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.res_is_x) begin
                if (four_state) begin
                    tests++;
                    if (result !== 32'hxxxxxxxx) begin
                        fails++;
                        $display("FAIL %s result: got %h want xxxxxxxx", e.name, result);
                    end
                end
            end else begin
                tests++;
                if (result !== e.exp_res) begin
                    fails++;
                    $display("FAIL %s result: got %h want %h", e.name, result, e.exp_res);
                end
                tests++;
                if (zero !== e.exp_zero) begin
                    fails++;
                    $display("FAIL %s zero: got %b want %b", e.name, zero, e.exp_zero);
                end
            end
            if (e.chk_q) begin
                tests++;
                if (result_q !== e.exp_q) begin
                    fails++;
                    $display("FAIL %s result_q: got %h want %h", e.name, result_q, e.exp_q);
                end
                tests++;
                if (zero_q !== e.exp_zq) begin
                    fails++;
                    $display("FAIL %s zero_q: got %b want %b", e.name, zero_q, e.exp_zq);
                end
            end
        end
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got timeout want completion");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        logic probe;
        probe       = 1'bx;
        four_state  = (probe === 1'bx);
        tests       = 0;
        fails       = 0;
        done        = 1'b0;
        rst_n       = 1'b0;
        a           = 32'h0;
        b           = 32'h0;
        alu_control = 4'b0000;

        // Reset: registered outputs forced, combinational path unaffected
        vec("rst_add",   4'b0000, 32'h5,        32'h3,        1'b0, 32'h00000008, 1'b0);
        vec("add_5_3",   4'b0000, 32'h5,        32'h3,        1'b1, 32'h00000008, 1'b0);
        vec("add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h1,        1'b1, 32'h80000000, 1'b0);
        vec("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h3,        1'b1, 32'h00000002, 1'b0);
        vec("sub_8_3",   4'b0001, 32'h8,        32'h3,        1'b1, 32'h00000005, 1'b0);
        vec("sub_0_1",   4'b0001, 32'h0,        32'h1,        1'b1, 32'hFFFFFFFF, 1'b0);
        vec("sub_1_1",   4'b0001, 32'h1,        32'h1,        1'b1, 32'h00000000, 1'b0);
        vec("sub_5_3",   4'b0001, 32'h5,        32'h3,        1'b1, 32'h00000002, 1'b0);
        vec("and",       4'b0010, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 1'b0);
        vec("and_mix",   4'b0010, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 32'h0F000F00, 1'b0);
        vec("or",        4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'hFFFFFFFF, 1'b0);
        vec("xor_a",     4'b0100, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'hFFFFFFFF, 1'b0);
        vec("xor_b",     4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0);
        vec("sll_4",     4'b0101, 32'h1,        32'h4,        1'b1, 32'h00000010, 1'b0);
        vec("sll_20",    4'b0101, 32'h1,        32'h20,       1'b1, 32'h00000001, 1'b0);
        vec("sll_31",    4'b0101, 32'h3,        32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0);
        vec("srl_4",     4'b0110, 32'h80,       32'h4,        1'b1, 32'h00000008, 1'b0);
        vec("srl_31",    4'b0110, 32'h80000000, 32'h1F,       1'b1, 32'h00000001, 1'b0);
        vec("sra_neg",   4'b0111, 32'h80000000, 32'h4,        1'b1, 32'hF8000000, 1'b0);
        vec("sra_pos",   4'b0111, 32'h7FFFFFFF, 32'h4,        1'b1, 32'h07FFFFFF, 1'b0);
        vec("sra_24",    4'b0111, 32'h80000000, 32'h24,       1'b1, 32'hF8000000, 1'b0);
        vec("slt_m1_1",  4'b1000, 32'hFFFFFFFF, 32'h1,        1'b1, 32'h00000001, 1'b0);
        vec("slt_1_m1",  4'b1000, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0);
        vec("slt_eq",    4'b1000, 32'h7,        32'h7,        1'b1, 32'h00000000, 1'b0);
        vec("sltu_1_m",  4'b1001, 32'h1,        32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b0);
        vec("sltu_m_1",  4'b1001, 32'hFFFFFFFF, 32'h1,        1'b1, 32'h00000000, 1'b0);
        vec("lui",       4'b1010, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678, 1'b0);
        vec("undef",     4'b1111, 32'h5,        32'h3,        1'b1, 32'h00000000, 1'b1);
        // Reset asserted mid-stream, then released: first edge captures result
        vec("rst_mid",   4'b0000, 32'h5,        32'h3,        1'b0, 32'h00000008, 1'b0);
        vec("post_rst",  4'b0100, 32'h0000FFFF, 32'h000000FF, 1'b1, 32'h0000FF00, 1'b0);
        vec("sub_zero",  4'b0001, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, opcode width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 a  input  32  operand A (shift source, SLT/SLTU left operand).
REQ-005 b  input  32  operand B (shift amount source, LUI immediate).
REQ-006 alu_control  input  4  operation select.
REQ-007 result  output  32  combinational operation result.
REQ-008 zero  output  1  combinational flag, 1 when result == 0.
REQ-009 result_q  output  32  registered copy of result.
REQ-010 zero_q  output  1  registered copy of zero.

Function
REQ-011 Opcode encoding SHALL be: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001, LUI=1010; 1011-1111 undefined.
REQ-012 result and zero SHALL be purely combinational from a, b, alu_control; zero latency, no dependence on clk/rst_n.
REQ-013 ADD: result = (a + b) mod 2^32; carry/overflow discarded, no flag (7FFFFFFF+1 = 80000000; FFFFFFFF+3 = 00000002).
REQ-014 SUB: result = (a - b) mod 2^32 (0 - 1 = FFFFFFFF).
REQ-015 AND/OR/XOR: bitwise a op b.
REQ-016 Shifts SHALL use only b[4:0] as amount; b[31:5] ignored (amount 0x20 behaves as 0).
REQ-017 SLL: a << b[4:0], zero fill; SRL: a >> b[4:0], zero fill; SRA: a >> b[4:0], fill with a[31].
REQ-018 SLT: result = 32'h1 if signed(a) < signed(b), else 0.
REQ-019 SLTU: result = 32'h1 if unsigned(a) < unsigned(b), else 0.
REQ-020 LUI: result = b unchanged (a ignored); upper-immediate alignment done upstream.
REQ-021 Undefined opcodes SHALL drive result = all X (32'hxxxxxxxx); zero is then X; synthesis may treat as don't-care.
REQ-022 zero SHALL equal reduction-NOR of result for every defined opcode, not only SUB.
REQ-023 On each rising clk edge with rst_n=1: result_q <= result, zero_q <= zero; one-cycle latency, no enable, no stall.

Reset
REQ-024 On rising clk edge with rst_n=0: result_q <= 32'h0, zero_q <= 1; combinational outputs unaffected.
REQ-025 Reset deasserted mid-stream: first edge with rst_n=1 captures the current combinational result; no extra flush cycles.
REQ-026 Before first reset edge result_q/zero_q are undefined; no power-on value required.

Verification
REQ-027 Arithmetic: ADD 5+3 -> 00000008; ADD 7FFFFFFF+1 -> 80000000; SUB 8-3 -> 00000005; SUB 0-1 -> FFFFFFFF; SUB 1-1 -> 0, zero=1; SUB 5-3 -> 2, zero=0.
REQ-028 Logic: AND F0F0F0F0&0F0F0F0F -> 0; OR same -> FFFFFFFF; XOR FFFF0000^0000FFFF -> FFFFFFFF; XOR FFFFFFFF^FFFFFFFF -> 0.
REQ-029 Shifts: SLL 1 by 4 -> 10; SLL 1 by 0x20 -> 1; SRL 80 by 4 -> 8; SRL 80000000 by 31 -> 1; SRA 80000000 by 4 -> F8000000; SRA 7FFFFFFF by 4 -> 07FFFFFF.
REQ-030 Compare/LUI: SLT FFFFFFFF,1 -> 1; SLT 1,FFFFFFFF -> 0; SLTU 1,FFFFFFFF -> 1; SLTU FFFFFFFF,1 -> 0; LUI b=12345678 -> 12345678.
REQ-031 Undefined: alu_control=1111, a=5, b=3 -> result all X (checked with case inequality).
REQ-032 Registered path: rst_n=0 for one edge -> result_q=0, zero_q=1; release, ADD 5+3 -> result_q=8, zero_q=0 after next edge; assert rst_n mid-stream -> result_q=0 at that edge.
